// File: rtl/ppu_requant.sv
// Post-processing requantizer: INT32 accumulators to INT8.
// Three-stage pipeline: bias add, scale multiply, round/ReLU/zero-point/saturate.
module ppu_requant #(
  parameter int NUM_LANES = 16,
  parameter int ACC_W     = 32,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_LANES*ACC_W-1:0] i_acc,
  input  logic                       i_valid,
  input  logic                       i_last,
  input  logic [15:0]                cfg_mult,
  input  logic [4:0]                 cfg_shift,
  input  logic [7:0]                 cfg_zp,
  input  logic                       cfg_relu,
  input  logic                       bias_we,
  input  logic [3:0]                 bias_addr,
  input  logic [31:0]                bias_wdata,
  input  logic                       i_clear,
  input  logic                       i_full,
  output logic [NUM_LANES*8-1:0]     o_data,
  output logic                       o_valid,
  output logic                       o_last,
  output logic [CNT_W-1:0]           o_count,
  output logic                       o_overflow,
  output logic                       o_busy
);

  localparam int BASE_W = (ACC_W > 32) ? ACC_W : 32;
  localparam int SUM_W  = BASE_W + 1;
  localparam int PROD_W = SUM_W + 17;
  localparam int RND_W  = PROD_W + 1;

  localparam logic signed [RND_W-1:0] SAT_HI = 127;
  localparam logic signed [RND_W-1:0] SAT_LO = -128;

  logic signed [31:0] bias_q [NUM_LANES];

  logic              s1_valid;
  logic              s1_last;
  logic [15:0]       s1_mult;
  logic [4:0]        s1_shift;
  logic signed [7:0] s1_zp;
  logic              s1_relu;

  logic              s2_valid;
  logic              s2_last;
  logic [4:0]        s2_shift;
  logic signed [7:0] s2_zp;
  logic              s2_relu;

  // Bias table; a write lands after the current cycle's stage-1 read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        bias_q[k] <= '0;
      end
    end else if (bias_we) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (int'(bias_addr) == k) begin
          bias_q[k] <= bias_wdata;
        end
      end
    end
  end

  // Valid/last shift chain; last is qualified by valid at entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
    end else begin
      s1_valid <= i_valid;
      s1_last  <= i_valid & i_last;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      o_valid  <= s2_valid;
      o_last   <= s2_last;
    end
  end

  // Config travels with the vector so mid-stream changes stay ordered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_mult  <= '0;
      s1_shift <= '0;
      s1_zp    <= '0;
      s1_relu  <= 1'b0;
      s2_shift <= '0;
      s2_zp    <= '0;
      s2_relu  <= 1'b0;
    end else begin
      if (i_valid) begin
        s1_mult  <= cfg_mult;
        s1_shift <= cfg_shift;
        s1_zp    <= cfg_zp;
        s1_relu  <= cfg_relu;
      end
      if (s1_valid) begin
        s2_shift <= s1_shift;
        s2_zp    <= s1_zp;
        s2_relu  <= s1_relu;
      end
    end
  end

  // Emitted-vector counter and sticky overflow; clear beats update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else if (i_clear) begin
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (o_valid) begin
        o_count <= o_count + CNT_W'(1);
      end
      if (o_valid && i_full) begin
        o_overflow <= 1'b1;
      end
    end
  end

  assign o_busy = s1_valid | s2_valid | o_valid;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic signed [ACC_W-1:0]  acc;
    logic signed [SUM_W-1:0]  sum_d;
    logic signed [SUM_W-1:0]  sum_q;
    logic signed [PROD_W-1:0] prod_d;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [RND_W-1:0]  half;
    logic signed [RND_W-1:0]  rnd;
    logic signed [RND_W-1:0]  shr;
    logic signed [RND_W-1:0]  val;
    logic [7:0]               sat_d;
    logic [7:0]               sat_q;

    // Stage 1: widened bias add, cannot wrap.
    always_comb begin
      acc   = $signed(i_acc[ACC_W*k +: ACC_W]);
      sum_d = SUM_W'(acc) + SUM_W'(bias_q[k]);
    end

    // Stage 2: signed sum times zero-extended multiplier.
    always_comb begin
      prod_d = PROD_W'(sum_q) * PROD_W'($signed({1'b0, s1_mult}));
    end

    // Stage 3: round half up, shift, ReLU, zero point, clamp.
    always_comb begin
      half = '0;
      if (s2_shift != 5'd0) begin
        half = RND_W'(1) << (s2_shift - 5'd1);
      end
      rnd = RND_W'(prod_q) + half;
      shr = rnd >>> s2_shift;
      if (s2_relu && shr < 0) begin
        shr = '0;
      end
      val = shr + RND_W'(s2_zp);
      if (val > SAT_HI) begin
        sat_d = 8'h7f;
      end else if (val < SAT_LO) begin
        sat_d = 8'h80;
      end else begin
        sat_d = val[7:0];
      end
    end

    // Per-lane data registers, loaded only when their stage is valid.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q  <= '0;
        prod_q <= '0;
        sat_q  <= '0;
      end else begin
        if (i_valid) begin
          sum_q <= sum_d;
        end
        if (s1_valid) begin
          prod_q <= prod_d;
        end
        if (s2_valid) begin
          sat_q <= sat_d;
        end
      end
    end

    assign o_data[8*k +: 8] = sat_q;
  end

endmodule

// File: tb/tb_ppu_requant.sv
// Random and directed stimulus for ppu_requant,
// checked against an arithmetic reference model.
module tb_ppu_requant;

  localparam int NL = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [NL*32-1:0] i_acc;
  logic           i_valid;
  logic           i_last;
  logic [15:0]    cfg_mult;
  logic [4:0]     cfg_shift;
  logic [7:0]     cfg_zp;
  logic           cfg_relu;
  logic           bias_we;
  logic [3:0]     bias_addr;
  logic [31:0]    bias_wdata;
  logic           i_clear;
  logic           i_full;
  logic [NL*8-1:0] o_data;
  logic           o_valid;
  logic           o_last;
  logic [15:0]    o_count;
  logic           o_overflow;
  logic           o_busy;

  ppu_requant #(.NUM_LANES(NL), .ACC_W(32), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_acc      (i_acc),
    .i_valid    (i_valid),
    .i_last     (i_last),
    .cfg_mult   (cfg_mult),
    .cfg_shift  (cfg_shift),
    .cfg_zp     (cfg_zp),
    .cfg_relu   (cfg_relu),
    .bias_we    (bias_we),
    .bias_addr  (bias_addr),
    .bias_wdata (bias_wdata),
    .i_clear    (i_clear),
    .i_full     (i_full),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_last     (o_last),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             due;
    logic [NL*8-1:0] data;
    logic           last;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_lasts = 0;

  exp_t           q[$];
  logic [NL*8-1:0] seen[$];
  longint         bias_m[NL];
  logic [15:0]    m_cnt;
  logic           m_ovf;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NL*8-1:0] ref_vec(
      input logic [NL*32-1:0] acc,
      input logic [15:0] m,
      input logic [4:0] sh,
      input logic [7:0] zp,
      input logic relu);
    logic [NL*8-1:0] res;
    longint s;
    longint p;
    longint r;
    res = '0;
    for (int k = 0; k < NL; k++) begin
      s = longint'($signed(acc[32*k +: 32])) + bias_m[k];
      p = s * longint'(m);
      if (sh == 5'd0) r = p;
      else r = (p + (longint'(1) <<< (sh - 1))) >>> sh;
      if (relu && r < 0) r = 0;
      r = r + longint'($signed(zp));
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      res[8*k +: 8] = r[7:0];
    end
    return res;
  endfunction

  logic exp_v;

  // Scoreboard: compare this cycle, then model the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_cnt = '0;
      m_ovf = 1'b0;
      for (int k = 0; k < NL; k++) bias_m[k] = 0;
      check("rst_valid", o_valid, 1'b0);
      check("rst_busy", o_busy, 1'b0);
      check("rst_cnt", o_count, 16'd0);
    end else begin
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      check("busy", o_busy, q.size() > 0);
      check("valid", o_valid, exp_v);
      check("count", o_count, m_cnt);
      check("ovf", o_overflow, m_ovf);
      if (exp_v) begin
        exp_t e;
        e = q.pop_front();
        check("data", o_data, e.data);
        check("last", o_last, e.last);
        seen.push_back(o_data);
        if (o_last) n_lasts++;
      end else begin
        check("last_idle", o_last, 1'b0);
      end
      if (i_clear) begin
        m_cnt = '0;
        m_ovf = 1'b0;
      end else begin
        if (exp_v) m_cnt = m_cnt + 16'd1;
        if (exp_v && i_full) m_ovf = 1'b1;
      end
      if (i_valid) begin
        exp_t n;
        n.due  = cyc + 3;
        n.data = ref_vec(i_acc, cfg_mult, cfg_shift,
                         cfg_zp, cfg_relu);
        n.last = i_last;
        q.push_back(n);
      end
      if (bias_we) bias_m[bias_addr] = longint'($signed(bias_wdata));
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_last  = 1'b0;
    repeat (n) step();
  endtask

  task automatic set_cfg(input logic [15:0] m, input logic [4:0] sh,
                         input logic [7:0] zp, input logic relu);
    cfg_mult  = m;
    cfg_shift = sh;
    cfg_zp    = zp;
    cfg_relu  = relu;
  endtask

  function automatic logic [NL*8-1:0] last_seen();
    if (seen.size() == 0) return '1;
    return seen[seen.size()-1];
  endfunction

  logic [NL*8-1:0] ev;
  logic [31:0]     a;

  initial begin
    rst = 1'b1;
    i_acc = '0;
    i_valid = 1'b0;
    i_last = 1'b0;
    set_cfg(16'd0, 5'd0, 8'd0, 1'b0);
    bias_we = 1'b0;
    bias_addr = '0;
    bias_wdata = '0;
    i_clear = 1'b0;
    i_full = 1'b0;
    step();
    step();
    check("reset_data", o_data, '0);
    check("reset_ovf", o_overflow, 1'b0);
    check("reset_last", o_last, 1'b0);
    rst = 1'b0;

    set_cfg(16'd16384, 5'd15, 8'd0, 1'b0);
    i_acc = {NL{32'd100}};
    i_valid = 1'b1;
    step();
    idle(5);
    check("basic_data", last_seen(), {NL{8'h32}});
    check("basic_count", o_count, 16'd1);

    set_cfg(16'd1, 5'd1, 8'd0, 1'b0);
    for (int k = 0; k < NL; k++) begin
      i_acc[32*k +: 32] = (k % 2 == 0) ? 32'd3 : -32'sd3;
      ev[8*k +: 8] = (k % 2 == 0) ? 8'h02 : 8'hff;
    end
    i_valid = 1'b1;
    step();
    idle(5);
    check("round", last_seen(), ev);

    seen.delete();
    set_cfg(16'd1, 5'd0, 8'd0, 1'b0);
    i_acc = {NL{-32'sd1000000}};
    i_valid = 1'b1;
    step();
    set_cfg(16'd1, 5'd0, 8'd5, 1'b1);
    step();
    set_cfg(16'd1, 5'd0, 8'd0, 1'b0);
    i_acc = {NL{32'd1000000}};
    step();
    idle(5);
    check("sat_n", seen.size(), 3);
    if (seen.size() == 3) begin
      check("sat_lo", seen[0], {NL{8'h80}});
      check("relu_zp", seen[1], {NL{8'h05}});
      check("sat_hi", seen[2], {NL{8'h7f}});
    end

    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    bias_we = 1'b1;
    for (int k = 0; k < NL; k++) begin
      bias_addr = 4'(k);
      bias_wdata = 32'(k);
      step();
    end
    bias_we = 1'b0;
    seen.delete();
    n_lasts = 0;
    i_acc = '0;
    for (int k = 0; k < NL; k++) ev[8*k +: 8] = 8'(k);
    for (int i = 0; i < 20; i++) begin
      i_valid = 1'b1;
      i_last = (i == 19);
      step();
    end
    idle(5);
    check("bias_lane", last_seen(), ev);
    check("burst_n", seen.size(), 20);
    check("burst_lasts", n_lasts, 1);
    check("burst_count", o_count, 16'd20);

    i_full = 1'b1;
    i_valid = 1'b1;
    step();
    idle(4);
    i_full = 1'b0;
    check("ovf_set", o_overflow, 1'b1);
    idle(3);
    check("ovf_sticky", o_overflow, 1'b1);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    check("ovf_clr", o_overflow, 1'b0);
    check("cnt_clr", o_count, 16'd0);

    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NL; k++) begin
        if ($urandom % 3 == 0) a = $urandom;
        else a = 32'($urandom_range(0, 600)) - 32'd300;
        i_acc[32*k +: 32] = a;
      end
      if ($urandom % 4 == 0) begin
        cfg_mult  = ($urandom % 2 == 0) ? 16'd1 : 16'($urandom);
        cfg_shift = 5'($urandom);
        cfg_zp    = 8'($urandom);
        cfg_relu  = 1'($urandom);
      end
      i_valid = ($urandom % 4) != 0;
      i_last  = ($urandom % 5) == 0;
      bias_we = ($urandom % 10) == 0;
      bias_addr = 4'($urandom);
      if ($urandom % 2 == 0) bias_wdata = $urandom;
      else bias_wdata = 32'($urandom_range(0, 200)) - 32'd100;
      i_clear = ($urandom % 30) == 0;
      i_full  = ($urandom % 7) == 0;
      step();
    end
    bias_we = 1'b0;
    i_clear = 1'b0;
    i_full = 1'b0;
    idle(5);

    i_acc = {NL{32'd77}};
    i_valid = 1'b1;
    step();
    step();
    seen.delete();
    i_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    idle(6);
    check("rst_fly_out", seen.size(), 0);
    check("rst_fly_busy", o_busy, 1'b0);
    set_cfg(16'd1, 5'd0, 8'd0, 1'b0);
    i_acc = '0;
    i_valid = 1'b1;
    step();
    idle(5);
    check("rst_bias", last_seen(), '0);
    check("rst_count", o_count, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
